dot_product_seq: RTL

- Parametrised, sequential fixed-point dot product: N signed weights × N unsigned pixels, one multiply-accumulate per cycle through a single MAC lane.
- Successor to the fixed 10-element neuron datapath; adds a start/valid handshake, a busy flag, a generic length and widths, output scaling, and saturation.
- Sits between the weight/pixel operand registers and the activation/classifier stage of the network.

---
 rtl/dp_pkg.sv | 31 +++
 rtl/dp_mac_lane.sv | 61 ++++++
 rtl/dot_product_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Package dp_pkg
// Shared definitions for the sequential dot-product datapath:
//   - clog2 helper used to size the accumulator and the element index
//   - FSM state encodings (IDLE, MUL, DRAIN, OUT)
//   - default operand/result widths
// Optional build macro used elsewhere in this slice: DOT_PRODUCT_RELU_EN
package dp_pkg;

    // Ceiling log2, evaluated at elaboration time for widths.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int DEF_WW = 19;
    localparam int DEF_PW = 10;
    localparam int DEF_OW = 27;

endpackage

// File: rtl/dp_mac_lane.sv
// Module dp_mac_lane
// Single multiply-accumulate lane: a registered signed-weight x unsigned-pixel
// product followed by a wide signed accumulator.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      zero the product and accumulator (wins over the enables)
//   mul_en     register wgt * zero-extended pix into the product register
//   acc_en     add the sign-extended product register into the accumulator
//   wgt, pix   current operand pair
//   acc        accumulator value
module dp_mac_lane
    import dp_pkg::*;
#(
    parameter int WW    = DEF_WW,
    parameter int PW    = DEF_PW,
    parameter int ACC_W = WW + PW + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    mul_en,
    input  logic                    acc_en,
    input  logic signed [WW-1:0]    wgt,
    input  logic        [PW-1:0]    pix,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PP_W = WW + PW;

    logic signed [PP_W-1:0] wgt_ext;
    logic signed [PP_W-1:0] pix_ext;
    logic signed [PP_W-1:0] prod;

    // Both operands are brought to the product width before multiplying.
    // The pixel gets zero-extension so it is always treated as non-negative;
    // the magnitude of any product fits in PP_W signed bits.
    always_comb begin
        wgt_ext = {{PW{wgt[WW-1]}}, wgt};
        pix_ext = {{WW{1'b0}}, pix};
    end

    // Product register feeds the accumulator one cycle later, so the
    // multiplier and adder never share a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            acc  <= '0;
        end else if (clear) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (mul_en) begin
                prod <= wgt_ext * pix_ext;
            end
            if (acc_en) begin
                acc <= acc + {{(ACC_W-PP_W){prod[PP_W-1]}}, prod};
            end
        end
    end

endmodule

// File: rtl/dot_product_seq.sv
// Module dot_product_seq
// Sequential fixed-point dot product of N signed weights and N unsigned
// pixels through one MAC lane, with start/valid handshake, busy flag,
// arithmetic output rescale (SHIFT) and signed saturation to OW bits.
// Build macro: DOT_PRODUCT_RELU_EN -- when defined, negative results are
// clamped to zero after saturation (latency unchanged).
// Ports:
//   clk          rising-edge clock
//   GlobalReset  asynchronous active-high reset, aborts any computation
//   start        request, only accepted while busy is low
//   wgt_flat     N weights, element i at [i*WW +: WW]
//   pix_flat     N pixels, element i at [i*PW +: PW]
//   busy         high while a computation is in flight
//   valid        one-cycle pulse when value is updated
//   value        signed result, held until the next valid
module dot_product_seq
    import dp_pkg::*;
#(
    parameter int N     = 10,
    parameter int WW    = DEF_WW,
    parameter int PW    = DEF_PW,
    parameter int OW    = DEF_OW,
    parameter int SHIFT = 0,
    parameter int ACC_W = WW + PW + clog2(N)
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 start,
    input  logic [N*WW-1:0]      wgt_flat,
    input  logic [N*PW-1:0]      pix_flat,
    output logic                 busy,
    output logic                 valid,
    output logic signed [OW-1:0] value
);

    localparam int IW = clog2(N);
    localparam int EW = ((ACC_W > OW) ? ACC_W : OW) + 1;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [1:0]              state;
    logic [IW-1:0]           index;
    logic [N*WW-1:0]         wgt_reg;
    logic [N*PW-1:0]         pix_reg;
    logic signed [WW-1:0]    wgt_sel;
    logic [PW-1:0]           pix_sel;
    logic                    last;
    logic                    lane_clear;
    logic                    lane_mul_en;
    logic                    lane_acc_en;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
    logic signed [EW-1:0]    shifted_ext;
    logic signed [OW-1:0]    saturated;
    logic signed [OW-1:0]    result;

    assign busy = (state != IDLE);

    // Operand pair for the current element, taken from the registered copy
    // so input changes after the start edge cannot disturb the result.
    always_comb begin
        wgt_sel = wgt_reg[index*WW +: WW];
        pix_sel = pix_reg[index*PW +: PW];
        last    = (index == IW'(N - 1));
    end

    // Lane control: products are formed throughout MUL; accumulation lags by
    // one cycle, so it starts at the second MUL cycle and finishes in DRAIN.
    always_comb begin
        lane_clear  = (state == IDLE) && start;
        lane_mul_en = (state == MUL);
        lane_acc_en = ((state == MUL) && (index != '0)) || (state == DRAIN);
    end

    dp_mac_lane #(
        .WW    (WW),
        .PW    (PW),
        .ACC_W (ACC_W)
    ) u_mac_lane (
        .clk    (clk),
        .rst    (GlobalReset),
        .clear  (lane_clear),
        .mul_en (lane_mul_en),
        .acc_en (lane_acc_en),
        .wgt    (wgt_sel),
        .pix    (pix_sel),
        .acc    (acc)
    );

    // Control FSM: latch operands on start, walk the index through all N
    // elements, one drain cycle for the last product, one output cycle.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state   <= IDLE;
            index   <= '0;
            wgt_reg <= '0;
            pix_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wgt_reg <= wgt_flat;
                        pix_reg <= pix_flat;
                        index   <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (last) begin
                        index <= '0;
                        state <= DRAIN;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output arithmetic: floor-rounding rescale, then clamp into OW signed.
    // The shifted sum is widened one bit beyond both widths so the limit
    // comparisons work whether ACC_W is wider or narrower than OW.
    always_comb begin
        shifted     = acc >>> SHIFT;
        shifted_ext = {{(EW-ACC_W){shifted[ACC_W-1]}}, shifted};
        if (shifted_ext > SAT_MAX) begin
            saturated = SAT_MAX[OW-1:0];
        end else if (shifted_ext < SAT_MIN) begin
            saturated = SAT_MIN[OW-1:0];
        end else begin
            saturated = shifted_ext[OW-1:0];
        end
`ifdef DOT_PRODUCT_RELU_EN
        result = saturated[OW-1] ? '0 : saturated;
`else
        result = saturated;
`endif
    end

    // Result register: captured on leaving OUT, which is also the edge that
    // drops busy, so a start in the valid cycle is accepted immediately.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            valid <= 1'b0;
            value <= '0;
        end else begin
            valid <= (state == OUT);
            if (state == OUT) begin
                value <= result;
            end
        end
    end

endmodule
